sine_sweep_controller: RTL and testbench
========================================

Name: sine_sweep_controller

Overview:
- Sequencer that drives the phase_step input of the quarter-wave sine generator to produce stepped linear frequency sweeps (chirps).
- Software or a test FSM loads start/stop/increment/dwell, pulses start; block steps phase_step from start to stop, holding each value for a programmable dwell.
- Supports single-shot or repeat; reports active, done and step index.

Parameters:
- STEP_WIDTH, 32, width of phase_step words (matches generator accumulator).
- DWELL_WIDTH, 24, width of dwell counter.
- COUNT_WIDTH, 16, width of step index counter.

Ports:
- clock  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request to begin a sweep (ignored unless IDLE)
- abort  input  1  terminate sweep immediately
- repeat_en  input  1  1 = restart from start_step after stop_step dwell
- start_step  input  STEP_WIDTH  first phase_step value
- stop_step  input  STEP_WIDTH  final phase_step value
- step_increment  input  STEP_WIDTH  added per step
- dwell_cycles  input  DWELL_WIDTH  each step held dwell_cycles+1 clocks
- phase_step  output  STEP_WIDTH  to sine generator
- sweep_active  output  1  high in DWELL state
- sweep_done  output  1  one-cycle pulse at sweep completion
- step_index  output  COUNT_WIDTH  index of current step (0 = start_step)

Behaviour:
- Reset (async, reset_n low): state IDLE, phase_step 0, sweep_active 0, sweep_done 0, step_index 0, dwell counter 0.
- All config inputs latched into shadow registers on the accepted start; changes during a sweep have no effect.
- States: IDLE, DWELL, ADVANCE, DONE.
- IDLE: start=1 -> latch config; next cycle phase_step=start_step, step_index=0, dwell counter=dwell_cycles, state DWELL. Latency start->new phase_step: 1 clock.
- DWELL: counter decrements each clock; at 0 go ADVANCE. Each step therefore visible for dwell_cycles+1 clocks in DWELL plus 1 ADVANCE cycle (phase_step unchanged during ADVANCE).
- ADVANCE: compute next = phase_step + step_increment in STEP_WIDTH+1 bits.
  - If phase_step == stop_step or phase_step >= stop_step: end of pass -> repeat_en (latched) ? reload start_step, step_index 0, DWELL : DONE.
  - Else if next >= stop_step or next carries out: phase_step=stop_step (clamp), step_index+1, DWELL.
  - Else phase_step=next, step_index+1, DWELL.
- DONE: sweep_done=1 for exactly one cycle; phase_step holds stop_step; -> IDLE.
- start_step >= stop_step: start_step held one dwell, then pass ends (no downward sweep).
- step_increment == 0 with start_step < stop_step: holds start_step indefinitely until abort.
- step_index saturates at all-ones; does not wrap.
- abort (any state, highest priority, incl. same cycle as start): next cycle state IDLE, phase_step 0, sweep_active 0, no sweep_done pulse.
- start while not IDLE: ignored.

Optional Feature:
- Macro SWEEP_PINGPONG_EN.
- Defined: extra state DWELL_DOWN/ADVANCE_DOWN; with repeat_en=1, after stop_step dwell the block steps down by step_increment (clamping at start_step) instead of reloading; alternates up/down forever until abort; step_index counts down on the descending pass. repeat_en=0 behaves as without macro.
- Undefined: repeat reloads start_step (sawtooth); no down states synthesized.

Decomposition:
- Package sine_sweep_pkg: state enum typedef (sweep_state_t), default widths as localparams, SWEEP_DIR_UP/DOWN constants.
- Sub-module sweep_dwell_timer (loadable down-counter with zero flag) is natural; instantiate once.

Test Plan:
- start_step=100, stop_step=400, inc=100, dwell=2, repeat=0 -> phase_step 100,200,300,400 each held 4 clocks (3 DWELL + 1 ADVANCE); one sweep_done pulse; returns IDLE with phase_step=400.
- stop_step=350, inc=100 -> sequence 100,200,300,350 (clamp); step_index ends 3.
- repeat=1, same config -> after 400 dwell, phase_step returns 100, step_index 0; no sweep_done; abort mid-step -> next clock phase_step=0, IDLE.
- start and abort same cycle in IDLE -> stays IDLE, phase_step 0; start pulsed during DWELL -> no effect.
- start_step=0xFFFF_FF00, stop_step=0xFFFF_FFFF, inc=0x200 -> carry detected, clamps to 0xFFFF_FFFF, no wrap to low value.
- reset_n asserted mid-DWELL -> all outputs 0 asynchronously; with SWEEP_PINGPONG_EN, repeat=1: 100..400 then 300,200,100,200...

Source files
------------

// File: rtl/sine_sweep_pkg.sv
// Shared types and default widths for the sine sweep controller.
// SWEEP_PINGPONG_EN adds the descending-pass states.
package sine_sweep_pkg;

    localparam int unsigned DEF_STEP_WIDTH  = 32;
    localparam int unsigned DEF_DWELL_WIDTH = 24;
    localparam int unsigned DEF_COUNT_WIDTH = 16;

    localparam logic SWEEP_DIR_UP   = 1'b0;
    localparam logic SWEEP_DIR_DOWN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DWELL    = 3'd1,
        ST_ADVANCE  = 3'd2,
        ST_DONE     = 3'd3
`ifdef SWEEP_PINGPONG_EN
        ,
        ST_DWELL_DOWN   = 3'd4,
        ST_ADVANCE_DOWN = 3'd5
`endif
    } sweep_state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter that holds each sweep step; zero_c flags expiry.
module sweep_dwell_timer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/sine_sweep_controller.sv
// Stepped linear chirp sequencer feeding the sine generator's phase_step.
// SWEEP_PINGPONG_EN: with repeat_en, alternate up/down passes instead of reloading.
module sine_sweep_controller
    import sine_sweep_pkg::*;
#(
    parameter int unsigned STEP_WIDTH  = DEF_STEP_WIDTH,
    parameter int unsigned DWELL_WIDTH = DEF_DWELL_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   repeat_en,
    input  logic [STEP_WIDTH-1:0]  start_step,
    input  logic [STEP_WIDTH-1:0]  stop_step,
    input  logic [STEP_WIDTH-1:0]  step_increment,
    input  logic [DWELL_WIDTH-1:0] dwell_cycles,
    output logic [STEP_WIDTH-1:0]  phase_step,
    output logic                   sweep_active,
    output logic                   sweep_done,
    output logic [COUNT_WIDTH-1:0] step_index
);

    sweep_state_t state_q, state_d;

    logic [STEP_WIDTH-1:0]  start_sh, stop_sh, inc_sh;
    logic [DWELL_WIDTH-1:0] dwell_sh;
    logic                   repeat_sh;

    logic [STEP_WIDTH-1:0]  phase_d;
    logic [COUNT_WIDTH-1:0] index_d;
    logic                   active_d, done_d, latch_cfg;

    logic                   timer_load, timer_dec, dwell_zero;
    logic [DWELL_WIDTH-1:0] timer_value;

    logic [STEP_WIDTH:0]    up_sum;
    logic [STEP_WIDTH-1:0]  up_next;
    logic [COUNT_WIDTH-1:0] index_up;

    sweep_dwell_timer #(.WIDTH(DWELL_WIDTH)) u_dwell_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .decrement  (timer_dec),
        .zero_c     (dwell_zero)
    );

    // Next ascending step: the extra bit catches carry so a wrap clamps to stop.
    always_comb begin
        up_sum   = {1'b0, phase_step} + {1'b0, inc_sh};
        up_next  = (up_sum[STEP_WIDTH] || (up_sum[STEP_WIDTH-1:0] >= stop_sh))
                   ? stop_sh : up_sum[STEP_WIDTH-1:0];
        index_up = (step_index == '1) ? step_index : step_index + COUNT_WIDTH'(1);
    end

`ifdef SWEEP_PINGPONG_EN
    logic [STEP_WIDTH:0]    down_diff;
    logic [STEP_WIDTH-1:0]  down_next;
    logic [COUNT_WIDTH-1:0] index_down;
    logic                   direction_c;

    // Next descending step: borrow or undershoot clamps to start.
    always_comb begin
        down_diff   = {1'b0, phase_step} - {1'b0, inc_sh};
        down_next   = (down_diff[STEP_WIDTH] || (down_diff[STEP_WIDTH-1:0] <= start_sh))
                      ? start_sh : down_diff[STEP_WIDTH-1:0];
        index_down  = (step_index == '0) ? step_index : step_index - COUNT_WIDTH'(1);
        direction_c = ((state_q == ST_DWELL_DOWN) || (state_q == ST_ADVANCE_DOWN))
                      ? SWEEP_DIR_DOWN : SWEEP_DIR_UP;
    end
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_step;
        index_d     = step_index;
        done_d      = 1'b0;
        latch_cfg   = 1'b0;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        timer_value = dwell_sh;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch_cfg   = 1'b1;
                    state_d     = ST_DWELL;
                    phase_d     = start_step;
                    index_d     = '0;
                    timer_load  = 1'b1;
                    timer_value = dwell_cycles;
                end
            end
            ST_DWELL: begin
                if (dwell_zero) state_d = ST_ADVANCE;
                else            timer_dec = 1'b1;
            end
            ST_ADVANCE: begin
                if (phase_step >= stop_sh) begin
                    if (repeat_sh) begin
                        timer_load = 1'b1;
`ifdef SWEEP_PINGPONG_EN
                        state_d = ST_DWELL_DOWN;
                        phase_d = down_next;
                        index_d = index_down;
`else
                        state_d = ST_DWELL;
                        phase_d = start_sh;
                        index_d = '0;
`endif
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d    = ST_DWELL;
                    phase_d    = up_next;
                    index_d    = index_up;
                    timer_load = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
`ifdef SWEEP_PINGPONG_EN
            ST_DWELL_DOWN: begin
                if (dwell_zero) state_d = ST_ADVANCE_DOWN;
                else            timer_dec = 1'b1;
            end
            ST_ADVANCE_DOWN: begin
                timer_load = 1'b1;
                if (phase_step <= start_sh) begin
                    state_d = ST_DWELL;
                    phase_d = up_next;
                    index_d = index_up;
                end else begin
                    state_d = ST_DWELL_DOWN;
                    phase_d = down_next;
                    index_d = index_down;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle start.
        if (abort) begin
            state_d     = ST_IDLE;
            phase_d     = '0;
            index_d     = '0;
            done_d      = 1'b0;
            latch_cfg   = 1'b0;
            timer_dec   = 1'b0;
            timer_load  = 1'b1;
            timer_value = '0;
        end

`ifdef SWEEP_PINGPONG_EN
        active_d = (state_d == ST_DWELL) || (state_d == ST_DWELL_DOWN);
`else
        active_d = (state_d == ST_DWELL);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            phase_step   <= '0;
            step_index   <= '0;
            sweep_active <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_step   <= phase_d;
            step_index   <= index_d;
            sweep_active <= active_d;
            sweep_done   <= done_d;
        end
    end

    // Shadow configuration: only the accepted start updates it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_sh  <= '0;
            stop_sh   <= '0;
            inc_sh    <= '0;
            dwell_sh  <= '0;
            repeat_sh <= 1'b0;
        end else if (latch_cfg) begin
            start_sh  <= start_step;
            stop_sh   <= stop_step;
            inc_sh    <= step_increment;
            dwell_sh  <= dwell_cycles;
            repeat_sh <= repeat_en;
        end
    end

endmodule

// File: tb/tb_sine_sweep_controller.sv
// Self-checking bench for sine_sweep_controller (default build, pingpong off).
module tb_sine_sweep_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        repeat_en = 1'b0;
    logic [31:0] start_step = '0;
    logic [31:0] stop_step = '0;
    logic [31:0] step_increment = '0;
    logic [23:0] dwell_cycles = '0;
    logic [31:0] phase_step;
    logic        sweep_active;
    logic        sweep_done;
    logic [15:0] step_index;

    sine_sweep_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .repeat_en      (repeat_en),
        .start_step     (start_step),
        .stop_step      (stop_step),
        .step_increment (step_increment),
        .dwell_cycles   (dwell_cycles),
        .phase_step     (phase_step),
        .sweep_active   (sweep_active),
        .sweep_done     (sweep_done),
        .step_index     (step_index)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] phase;
        logic        active;
        logic        done;
        logic [15:0] idx;
        logic        idx_chk;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  cur;
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    string tag = "reset";

    // Expected per-cycle trace from the sweep rules: list the step values,
    // each held dwell+1 active cycles plus one inactive cycle.
    task automatic gen(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                       input int dwell, input bit rep, input int max_n);
        logic [63:0] steps[$];
        logic [63:0] v;
        exp_t x;
        int n;
        v = 64'(s);
        steps.push_back(v);
        while (v < 64'(e) && inc != 0) begin
            v = v + 64'(inc);
            if (v > 64'(e)) v = 64'(e);
            steps.push_back(v);
        end
        n = 0;
        do begin
            for (int i = 0; i < steps.size(); i++) begin
                for (int c = 0; c < dwell + 2; c++) begin
                    if (n < max_n) begin
                        x.phase = steps[i][31:0]; x.active = (c <= dwell); x.done = 1'b0;
                        x.idx = 16'(i); x.idx_chk = 1'b1;
                        exp_q.push_back(x); n++;
                    end
                end
            end
        end while (rep && n < max_n);
        if (!rep) begin
            for (int k = 0; k < 3; k++) begin
                if (n < max_n) begin
                    x.phase = steps[steps.size()-1][31:0]; x.active = 1'b0; x.done = (k == 0);
                    x.idx = 16'(steps.size() - 1); x.idx_chk = 1'b1;
                    exp_q.push_back(x); n++;
                end
            end
        end
    endtask

    task automatic push_idle_zero(input int cnt);
        exp_t x;
        for (int k = 0; k < cnt; k++) begin
            x.phase = '0; x.active = 1'b0; x.done = 1'b0; x.idx = '0; x.idx_chk = 1'b0;
            exp_q.push_back(x);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                          input int dwell, input bit rep);
        start_step = s; stop_step = e; step_increment = inc;
        dwell_cycles = 24'(dwell); repeat_en = rep;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain(input int bound);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(negedge clock);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: %0d entries left, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Per-cycle compare against the model trace.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            n_cmp++;
            if (phase_step !== cur.phase || sweep_active !== cur.active ||
                sweep_done !== cur.done || (cur.idx_chk && step_index !== cur.idx)) begin
                n_err++;
                $display("FAIL %s[%0d]: got ph=%h act=%b done=%b idx=%0d, expected ph=%h act=%b done=%b idx=%0d",
                         tag, cyc, phase_step, sweep_active, sweep_done, step_index,
                         cur.phase, cur.active, cur.done, cur.idx);
            end
            cyc++;
        end else begin
            cyc = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_phase", 64'(phase_step), 64'd0);
        check("reset_active", 64'(sweep_active), 64'd0);
        check("reset_done", 64'(sweep_done), 64'd0);
        check("reset_index", 64'(step_index), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        tag = "basic";
        gen(32'd100, 32'd400, 32'd100, 2, 1'b0, 1000);
        check("pin_basic_len", 64'(exp_q.size()), 64'd19);
        check("pin_basic_p4", 64'(exp_q[4].phase), 64'd200);
        check("pin_basic_adv", 64'(exp_q[3].active), 64'd0);
        check("pin_basic_done", 64'(exp_q[16].done), 64'd1);
        launch(32'd100, 32'd400, 32'd100, 2, 1'b0);
        // start with new config during DWELL must be ignored
        start_step = 32'd7; stop_step = 32'd9; step_increment = 32'd1; dwell_cycles = 24'd0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain(100);
        check("basic_final_phase", 64'(phase_step), 64'd400);

        tag = "clamp";
        gen(32'd100, 32'd350, 32'd100, 2, 1'b0, 1000);
        check("pin_clamp_last", 64'(exp_q[12].phase), 64'd350);
        launch(32'd100, 32'd350, 32'd100, 2, 1'b0);
        drain(100);
        check("clamp_final_index", 64'(step_index), 64'd3);
        check("clamp_final_phase", 64'(phase_step), 64'd350);

        tag = "start_abort_idle";
        push_idle_zero(2);
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        drain(20);

        tag = "repeat";
        gen(32'd100, 32'd400, 32'd100, 1, 1'b1, 19);
        check("pin_repeat_reload", 64'(exp_q[12].phase), 64'd100);
        check("pin_repeat_idx0", 64'(exp_q[12].idx), 64'd0);
        launch(32'd100, 32'd400, 32'd100, 1, 1'b1);
        drain(100);
        tag = "repeat_abort";
        push_idle_zero(3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat_en = 1'b0;
        drain(20);

        tag = "carry";
        gen(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 0, 1'b0, 1000);
        check("pin_carry_clamp", 64'(exp_q[2].phase), 64'hFFFF_FFFF);
        check("pin_carry_done", 64'(exp_q[4].done), 64'd1);
        launch(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 0, 1'b0);
        drain(100);

        tag = "start_ge_stop";
        gen(32'd500, 32'd400, 32'd100, 1, 1'b0, 1000);
        check("pin_ge_len", 64'(exp_q.size()), 64'd6);
        check("pin_ge_done_phase", 64'(exp_q[3].phase), 64'd500);
        launch(32'd500, 32'd400, 32'd100, 1, 1'b0);
        drain(100);

        tag = "async_reset";
        gen(32'd100, 32'd400, 32'd100, 2, 1'b0, 2);
        launch(32'd100, 32'd400, 32'd100, 2, 1'b0);
        drain(20);
        #2 reset_n = 1'b0;
        #1;
        check("areset_phase", 64'(phase_step), 64'd0);
        check("areset_active", 64'(sweep_active), 64'd0);
        check("areset_done", 64'(sweep_done), 64'd0);
        check("areset_index", 64'(step_index), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        tag = "after_reset";
        gen(32'd10, 32'd30, 32'd10, 0, 1'b0, 1000);
        launch(32'd10, 32'd30, 32'd10, 0, 1'b0);
        drain(100);
        check("after_reset_phase", 64'(phase_step), 64'd30);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
